// File: rtl/alu_share_ctrl.sv
// Shares one 4-bit ALU among NREQ requesters with round-robin arbitration,
// one operation in flight, and a result held until its requester accepts it.

// 4-bit ALU datapath: add, add-plus-one, and, or (results modulo 16)
module alu (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [1:0] op_i,
    output logic [3:0] y_o
);

    // Pure combinational operation select
    always_comb begin
        y_o = '0;
        case (op_i)
            2'b00:   y_o = a_i + b_i;
            2'b01:   y_o = a_i + b_i + 4'd1;
            2'b10:   y_o = a_i & b_i;
            default: y_o = a_i | b_i;
        endcase
    end

endmodule

module alu_share_ctrl #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    input  logic [2*NREQ-1:0]   req_op,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [3:0]          rsp_data,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     last_id_q, last_id_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [3:0]         a_q, a_d;
    logic [3:0]         b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [3:0]         rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic [3:0]         a_arr [NREQ];
    logic [3:0]         b_arr [NREQ];
    logic [1:0]         op_arr [NREQ];
    logic               found_c;
    logic [IDW-1:0]     win_c;
    logic [IDW-1:0]     idx_c;
    logic [3:0]         alu_y_c;

    // Unpack the per-requester operand buses
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[4*i +: 4];
        assign b_arr[i]  = req_b[4*i +: 4];
        assign op_arr[i] = req_op[2*i +: 2];
    end

    // Round-robin search starting just after the last completed requester
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx_c = IDW'((32'(last_id_q) + k) % NREQ);
            if (!found_c && req_valid[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
    end

    alu u_alu (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .y_o  (alu_y_c)
    );

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        op_count_d = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    id_d    = win_c;
                    a_d     = a_arr[win_c];
                    b_d     = b_arr[win_c];
                    op_d    = op_arr[win_c];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d = alu_y_c;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready[id_q]) begin
                    last_id_d = id_q;
                    if (op_count_q != {CNT_W{1'b1}}) begin
                        op_count_d = op_count_q + CNT_W'(1);
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_id_q  <= IDW'(NREQ - 1);
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            last_id_q  <= last_id_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            op_count_q <= op_count_d;
        end
    end

    // Handshake outputs decoded from state; req_ready is a same-cycle grant
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == S_IDLE && found_c) begin
            req_ready = NREQ'(1) << win_c;
        end
        if (state_q == S_RESP) begin
            rsp_valid = NREQ'(1) << id_q;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign rsp_data = rsp_data_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a result scoreboard.
module tb_alu_share_ctrl;

    localparam int unsigned NREQ = 4;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [2*NREQ-1:0] req_op;
    logic [NREQ-1:0]   rsp_ready;
    logic [NREQ-1:0]   req_ready,  req_ready4;
    logic [NREQ-1:0]   rsp_valid,  rsp_valid4;
    logic [3:0]        rsp_data,   rsp_data4;
    logic              busy,       busy4;
    logic [15:0]       op_count;
    logic [3:0]        op_count4;

    alu_share_ctrl #(.NREQ(4), .IDW(2), .CNT_W(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    alu_share_ctrl #(.NREQ(4), .IDW(2), .CNT_W(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_ready (req_ready4),
        .rsp_valid (rsp_valid4),
        .rsp_data  (rsp_data4),
        .rsp_ready (rsp_ready),
        .busy      (busy4),
        .op_count  (op_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_pass;
    int   n_fail;
    int   n_total;
    int   exp_count;
    int   exp_count4;

    function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        logic [4:0] s;
        case (op)
            2'b00:   s = {1'b0, a} + {1'b0, b};
            2'b01:   s = {1'b0, a} + {1'b0, b} + 5'd1;
            2'b10:   s = {1'b0, a & b};
            default: s = {1'b0, a | b};
        endcase
        return s[3:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'(0));
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        check({tag, "_rsp_data"},  32'(rsp_data),  32'(0));
        check({tag, "_busy"},      32'(busy),      32'(0));
        check({tag, "_op_count"},  32'(op_count),  32'(0));
        check({tag, "_op_count4"}, 32'(op_count4), 32'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        sb.delete();
        exp_count  = 0;
        exp_count4 = 0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // One full transaction for requester id, which must be the arbitration winner.
    // hold: cycles spent in RESP with rsp_ready[id] low; keep: leave req_valid/operands untouched.
    task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op, input int hold, input bit keep);
        exp_t       e;
        logic [3:0] held;
        req_valid[id]      = 1'b1;
        req_a[4*id +: 4]   = a;
        req_b[4*id +: 4]   = b;
        req_op[2*id +: 2]  = op;
        rsp_ready[id]      = (hold == 0);
        #1;
        check("accept_req_ready", 32'(req_ready), 32'(1) << id);
        check("accept_busy", 32'(busy), 32'(0));
        sb.push_back('{id: id, data: model(a, b, op)});
        step();
        if (!keep) begin
            req_valid[id]     = 1'b0;
            req_a[4*id +: 4]  = 4'($urandom);
            req_b[4*id +: 4]  = 4'($urandom);
            req_op[2*id +: 2] = 2'($urandom);
        end
        #1;
        check("exec_busy", 32'(busy), 32'(1));
        check("exec_rsp_valid", 32'(rsp_valid), 32'(0));
        check("exec_req_ready", 32'(req_ready), 32'(0));
        step();
        check("sb_nonempty", 32'(sb.size() != 0), 32'(1));
        e = sb.pop_front();
        check("resp_rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
        check("resp_rsp_data", 32'(rsp_data), 32'(e.data));
        held = rsp_data;
        for (int c = 0; c < hold; c++) begin
            step();
            check("hold_rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
            check("hold_rsp_data", 32'(rsp_data), 32'(held));
            check("hold_busy", 32'(busy), 32'(1));
            check("hold_req_ready", 32'(req_ready), 32'(0));
        end
        if (hold != 0) rsp_ready[id] = 1'b1;
        step();
        if (exp_count < 65535) exp_count++;
        if (exp_count4 < 15) exp_count4++;
        check("done_rsp_valid", 32'(rsp_valid), 32'(0));
        check("done_op_count", 32'(op_count), 32'(exp_count));
        check("done_op_count4", 32'(op_count4), 32'(exp_count4));
    endtask

    initial begin
        n_pass     = 0;
        n_fail     = 0;
        n_total    = 0;
        exp_count  = 0;
        exp_count4 = 0;
        rst_n      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        rsp_ready  = '0;
        #2;
        do_reset();

        // Add and add-plus-one on requester 0
        run_op(0, 4'h7, 4'h9, 2'b00, 0, 1'b0);
        run_op(0, 4'h7, 4'h9, 2'b01, 0, 1'b0);

        // And / or on requester 2
        rsp_ready = '0;
        run_op(2, 4'hC, 4'hA, 2'b10, 0, 1'b0);
        run_op(2, 4'hC, 4'hA, 2'b11, 0, 1'b0);

        // Round-robin with all requesters continuously valid
        rsp_ready = '0;
        do_reset();
        req_a  = 16'h4321;
        req_b  = 16'h5A3F;
        req_op = 8'b11_10_01_00;
        req_valid = '1;
        rsp_ready = '1;
        for (int g = 0; g < 6; g++) begin
            run_op(g % 4, req_a[4*(g%4) +: 4], req_b[4*(g%4) +: 4], req_op[2*(g%4) +: 2], 0, 1'b1);
        end
        check("rr_op_count6", 32'(op_count), 32'(6));

        // Back-pressure in RESP; other requesters' rsp_ready must be ignored
        req_valid = '0;
        rsp_ready = 4'b1101;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        // last_id is 1 after six grants, so requester 2 wins over 0 and 3
        run_op(2, 4'h5, 4'h6, 2'b00, 5, 1'b0);

        // Asynchronous reset during EXEC
        req_valid = '0;
        rsp_ready = '1;
        req_valid[1] = 1'b1;
        // last_id is 2, so requester 3 then 0 then 1 would be the search order
        req_a[7:4] = 4'h3;
        req_b[7:4] = 4'h4;
        req_op[3:2] = 2'b00;
        #1;
        check("pre_rst_req_ready", 32'(req_ready), 32'(4'b0010));
        step();
        req_valid = '0;
        #1;
        check("pre_rst_busy", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midexec_rst");
        sb.delete();
        exp_count  = 0;
        exp_count4 = 0;
        step();
        step();
        check("in_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        rst_n = 1'b1;
        req_valid = 4'b0011;
        #1;
        check("post_rst_grant", 32'(req_ready), 32'(4'b0001));
        run_op(0, 4'h1, 4'h2, 2'b01, 0, 1'b0);
        run_op(1, 4'hF, 4'h1, 2'b00, 0, 1'b0);

        // Exhaustive sweep on requester 3
        req_valid = '0;
        rsp_ready = 4'b1000;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int op = 0; op < 4; op++) begin
                    run_op(3, 4'(a), 4'(b), 2'(op), 0, 1'b0);
                end
            end
        end
        check("sat_op_count4", 32'(op_count4), 32'(15));
        check("final_op_count", 32'(op_count), 32'(1026));
        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
